index_reg_bank: RTL and testbench
=================================

# index_reg_bank

Parametrised bank of per-core loop/index registers for the multicore datapath. Each channel is an up/down counter with bus load, clear-to-core-base, stride stepping, a programmable limit and a registered compare flag, so the control unit branches on loop termination without a combinational compare path. Cores differ only in `CORE_ID` and `STRIDE`, which lets N cores walk interleaved index ranges of one shared array. Sits beside the register file; reads `BusOut` and drives the branch-condition inputs.

## Interface
- `WIDTH`, 8: counter/limit width in bits
- `NUM_CH`, 4: number of independent index channels (≥2)
- `SEL_W`, `$clog2(NUM_CH)`: channel-select width (derived)
- `CORE_ID`, 1: value loaded on reset and on CLR (core's base index)
- `STRIDE`, 1: step for INC/DEC (normally the core count)

- `Clk`  in  1  clock; all state updates on rising edge
- `RST`  in  1  synchronous, active-high reset
- `Wen`  in  1  load `BusOut` into channel `Wsel`
- `Wsel`  in  SEL_W  load target channel
- `BusOut`  in  WIDTH  load data
- `Op`  in  2  00 NOP, 01 CLR, 10 INC, 11 DEC
- `Osel`  in  SEL_W  Op target channel
- `Lwen`  in  1  load `BusOut` into limit of channel `Wsel`
- `Cmp_mode`  in  2  00 LE (val≤lim), 01 LT, 10 EQ, 11 GE; unsigned, global to all channels
- `Rsel`  in  SEL_W  read-port select
- `dout`  out  WIDTH  value of channel `Rsel` (combinational mux of registered values)
- `z`  out  NUM_CH  registered per-channel compare flag
- `ovf`  out  NUM_CH  sticky per-channel wrap flag

## Operation
- Reset (`RST`=1): all values ← `CORE_ID`, all limits ← all-ones, `ovf` ← 0, `z` ← compare(`CORE_ID`, all-ones, `Cmp_mode`) as sampled that cycle. RST overrides every other input.
- Per channel c, value priority: `Wen`&&`Wsel`==c → `BusOut`; else `Osel`==c: CLR → `CORE_ID`, INC → val+STRIDE, DEC → val−STRIDE; else hold.
- `Wen` and `Op` on different channels both take effect in the same cycle; on the same channel, `Wen` wins and Op is dropped.
- `Lwen` writes limit[`Wsel`]; may coincide with `Wen` (same data to value and limit).
- Arithmetic modulo 2^WIDTH. INC carry-out or DEC borrow sets `ovf[c]` (sticky); `Wen` or CLR on channel c clears `ovf[c]`. Same-cycle wrap and clear: clear wins only if the clear event is the one applied (Wen over Op).
- `z[c]` recomputed every cycle from the *next* value, *next* limit and current `Cmp_mode`; no latch-style sensitivity to a single input.
- Out-of-range selects (≥NUM_CH, non-power-of-2 NUM_CH): writes/ops ignored, `dout` = 0.

## Timing
- Load/op in cycle n → new value on `dout` and matching `z`, `ovf` in cycle n+1 (single-cycle latency, aligned).
- `Cmp_mode` change in cycle n → `z` reflects it in n+1.
- Back-to-back INC every cycle supported; no stalls, no handshake.
- `Rsel` → `dout` is combinational, zero-cycle.
- RST asserted mid-sequence: state at n+1 is reset state regardless of Wen/Op/Lwen in cycle n.

## Structure
- Shared package `index_reg_pkg`: Op encodings (`OP_NOP/CLR/INC/DEC`), compare-mode encodings (`CMP_LE/LT/EQ/GE`), and compare function.
- One sub-module `index_channel` (one value, limit, z, ovf, next-state logic) generated NUM_CH times; top does select decode and read mux.

## Test plan
- Reset, defaults (WIDTH=8, CORE_ID=1, STRIDE=1, LE): after RST, all channels `dout`=1, `z`=all-ones, `ovf`=0.
- Loop: Lwen limit[0]=3, INC ch0 each cycle with LE → `dout` 2,3,4; `z[0]` 1,1,0 aligned with each value.
- Wrap: STRIDE=4, Wen ch1=0xFE, INC → `dout`=0x02, `ovf[1]`=1; CLR ch1 → `dout`=CORE_ID, `ovf[1]`=0.
- Conflict: Wen ch2=0x10 with INC ch2 → 0x10; Wen ch2=0x10 with INC ch3 (ch3=1) → ch2=0x10, ch3=2 same cycle.
- Mode sweep: ch0=5, limit=5; `Cmp_mode` LE,LT,EQ,GE → `z[0]` 1,0,1,1 each one cycle after the mode change.
- RST mid-op: Wen ch0=0x40 with RST=1 → ch0=CORE_ID, limit all-ones next cycle.

Source files
------------

// File: rtl/index_reg_bank_pkg.sv
// Shared encodings and compare helper
// for the per-core index register bank.
package index_reg_pkg;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_CLR = 2'b01,
    OP_INC = 2'b10,
    OP_DEC = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    CMP_LE = 2'b00,
    CMP_LT = 2'b01,
    CMP_EQ = 2'b10,
    CMP_GE = 2'b11
  } cmp_mode_t;

  // Width-agnostic: caller supplies val<lim and val==lim.
  function automatic logic cmp_f(
    input cmp_mode_t m,
    input logic      lt,
    input logic      eq
  );
    logic r;
    case (m)
      CMP_LE:  r = lt | eq;
      CMP_LT:  r = lt;
      CMP_EQ:  r = eq;
      default: r = ~lt;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/index_channel.sv
// One index channel: value, limit,
// registered compare flag and sticky wrap flag.
module index_channel
  import index_reg_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int CORE_ID = 1,
  parameter int STRIDE  = 1
) (
  input  logic             Clk,
  input  logic             RST,
  input  logic             i_wen,
  input  logic             i_lwen,
  input  op_t              i_op,
  input  logic [WIDTH-1:0] i_data,
  input  cmp_mode_t        i_mode,
  output logic [WIDTH-1:0] o_val,
  output logic             o_z,
  output logic             o_ovf
);

  localparam logic [WIDTH-1:0] BASE = WIDTH'(CORE_ID);
  localparam logic [WIDTH-1:0] STEP = WIDTH'(STRIDE);
  localparam logic [WIDTH-1:0] ONES = '1;

  logic [WIDTH-1:0] r_val;
  logic [WIDTH-1:0] r_lim;
  logic             r_z;
  logic             r_ovf;

  logic [WIDTH:0]   w_inc;
  logic [WIDTH:0]   w_dec;
  logic [WIDTH-1:0] w_val_nx;
  logic [WIDTH-1:0] w_lim_nx;
  logic             w_ovf_nx;
  logic [WIDTH-1:0] w_cv;
  logic [WIDTH-1:0] w_cl;
  logic             w_z_nx;

  assign w_inc = {1'b0, r_val} + {1'b0, STEP};
  assign w_dec = {1'b0, r_val} - {1'b0, STEP};

  always_comb begin
    w_val_nx = r_val;
    w_ovf_nx = r_ovf;
    if (i_wen) begin
      w_val_nx = i_data;
      w_ovf_nx = 1'b0;
    end else begin
      case (i_op)
        OP_CLR: begin
          w_val_nx = BASE;
          w_ovf_nx = 1'b0;
        end
        OP_INC: begin
          w_val_nx = w_inc[WIDTH-1:0];
          w_ovf_nx = r_ovf | w_inc[WIDTH];
        end
        OP_DEC: begin
          w_val_nx = w_dec[WIDTH-1:0];
          w_ovf_nx = r_ovf | w_dec[WIDTH];
        end
        default: ;
      endcase
    end
  end

  assign w_lim_nx = i_lwen ? i_data : r_lim;

  // z tracks the state being loaded, so it is aligned with the value.
  assign w_cv   = RST ? BASE : w_val_nx;
  assign w_cl   = RST ? ONES : w_lim_nx;
  assign w_z_nx = cmp_f(i_mode, w_cv < w_cl, w_cv == w_cl);

  always_ff @(posedge Clk) begin
    if (RST) begin
      r_val <= BASE;
      r_lim <= ONES;
      r_ovf <= 1'b0;
      r_z   <= w_z_nx;
    end else begin
      r_val <= w_val_nx;
      r_lim <= w_lim_nx;
      r_ovf <= w_ovf_nx;
      r_z   <= w_z_nx;
    end
  end

  assign o_val = r_val;
  assign o_z   = r_z;
  assign o_ovf = r_ovf;

endmodule

// File: rtl/index_reg_bank.sv
// Bank of loop/index channels with select
// decode and combinational read mux.
module index_reg_bank
  import index_reg_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NUM_CH  = 4,
  parameter int SEL_W   = $clog2(NUM_CH),
  parameter int CORE_ID = 1,
  parameter int STRIDE  = 1
) (
  input  logic              Clk,
  input  logic              RST,
  input  logic              Wen,
  input  logic [SEL_W-1:0]  Wsel,
  input  logic [WIDTH-1:0]  BusOut,
  input  logic [1:0]        Op,
  input  logic [SEL_W-1:0]  Osel,
  input  logic              Lwen,
  input  logic [1:0]        Cmp_mode,
  input  logic [SEL_W-1:0]  Rsel,
  output logic [WIDTH-1:0]  dout,
  output logic [NUM_CH-1:0] z,
  output logic [NUM_CH-1:0] ovf
);

  logic [WIDTH-1:0] w_val [NUM_CH];
  cmp_mode_t        w_mode;

  assign w_mode = cmp_mode_t'(Cmp_mode);

  // Out-of-range selects never match a channel.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic w_wsel;
    logic w_osel;

    assign w_wsel = (Wsel == SEL_W'(c));
    assign w_osel = (Osel == SEL_W'(c));

    index_channel #(
      .WIDTH   (WIDTH),
      .CORE_ID (CORE_ID),
      .STRIDE  (STRIDE)
    ) u_ch (
      .Clk    (Clk),
      .RST    (RST),
      .i_wen  (Wen & w_wsel),
      .i_lwen (Lwen & w_wsel),
      .i_op   (w_osel ? op_t'(Op) : OP_NOP),
      .i_data (BusOut),
      .i_mode (w_mode),
      .o_val  (w_val[c]),
      .o_z    (z[c]),
      .o_ovf  (ovf[c])
    );
  end

  always_comb begin
    dout = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (Rsel == SEL_W'(c)) dout = w_val[c];
    end
  end

endmodule

// File: tb/tb_index_reg_bank.sv
// Directed self-checking bench for index_reg_bank:
// dut_a defaults, dut_b STRIDE=4 with NUM_CH=3.
module tb_index_reg_bank;

  logic       Clk = 1'b0;
  logic       RST = 1'b0;
  logic       Wen = 1'b0;
  logic [1:0] Wsel = '0;
  logic [7:0] BusOut = '0;
  logic [1:0] Op = 2'b00;
  logic [1:0] Osel = '0;
  logic       Lwen = 1'b0;
  logic [1:0] Cmp_mode = 2'b00;
  logic [1:0] Rsel = '0;

  logic [7:0] dout_a;
  logic [3:0] z_a;
  logic [3:0] ovf_a;
  logic [7:0] dout_b;
  logic [2:0] z_b;
  logic [2:0] ovf_b;

  int n_pass = 0;
  int n_total = 0;

  always #5 Clk = ~Clk;

  index_reg_bank #(
    .WIDTH(8), .NUM_CH(4), .CORE_ID(1), .STRIDE(1)
  ) dut_a (
    .Clk(Clk), .RST(RST), .Wen(Wen), .Wsel(Wsel),
    .BusOut(BusOut), .Op(Op), .Osel(Osel),
    .Lwen(Lwen), .Cmp_mode(Cmp_mode), .Rsel(Rsel),
    .dout(dout_a), .z(z_a), .ovf(ovf_a)
  );

  index_reg_bank #(
    .WIDTH(8), .NUM_CH(3), .CORE_ID(1), .STRIDE(4)
  ) dut_b (
    .Clk(Clk), .RST(RST), .Wen(Wen), .Wsel(Wsel),
    .BusOut(BusOut), .Op(Op), .Osel(Osel),
    .Lwen(Lwen), .Cmp_mode(Cmp_mode), .Rsel(Rsel),
    .dout(dout_b), .z(z_b), .ovf(ovf_b)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    RST = 1'b0; Wen = 1'b0; Lwen = 1'b0; Op = 2'b00;
  endtask

  task automatic do_reset();
    idle();
    Cmp_mode = 2'b00;
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      Rsel = 2'(c);
      #1;
      n_total++;
      if (dout_a !== 8'h01)
        $display("FAIL reset_dout ch%0d got %h exp 01", c, dout_a);
      else n_pass++;
    end
    n_total++;
    if (z_a !== 4'hF || ovf_a !== 4'h0)
      $display("FAIL reset_flags z=%h ovf=%h exp z=f ovf=0", z_a, ovf_a);
    else n_pass++;
  endtask

  task automatic test_loop();
    logic [7:0] ev [3];
    logic       ez [3];
    ev[0] = 8'h02; ev[1] = 8'h03; ev[2] = 8'h04;
    ez[0] = 1'b1;  ez[1] = 1'b1;  ez[2] = 1'b0;
    do_reset();
    Lwen = 1'b1; Wsel = 2'd0; BusOut = 8'h03;
    tick();
    Lwen = 1'b0;
    Op = 2'b10; Osel = 2'd0; Rsel = 2'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if (dout_a !== ev[i] || z_a[0] !== ez[i])
        $display("FAIL loop_inc step%0d got %h z%b exp %h z%b",
                 i, dout_a, z_a[0], ev[i], ez[i]);
      else n_pass++;
    end
    idle();
  endtask

  task automatic test_wrap();
    do_reset();
    Wen = 1'b1; Wsel = 2'd1; BusOut = 8'hFE;
    tick();
    Wen = 1'b0; Op = 2'b10; Osel = 2'd1; Rsel = 2'd1;
    tick();
    n_total++;
    if (dout_b !== 8'h02 || ovf_b[1] !== 1'b1)
      $display("FAIL wrap_inc got %h ovf%b exp 02 ovf1", dout_b, ovf_b[1]);
    else n_pass++;
    tick();
    n_total++;
    if (dout_b !== 8'h06 || ovf_b[1] !== 1'b1)
      $display("FAIL wrap_sticky got %h ovf%b exp 06 ovf1", dout_b, ovf_b[1]);
    else n_pass++;
    Op = 2'b01;
    tick();
    n_total++;
    if (dout_b !== 8'h01 || ovf_b[1] !== 1'b0)
      $display("FAIL wrap_clr got %h ovf%b exp 01 ovf0", dout_b, ovf_b[1]);
    else n_pass++;
    Op = 2'b11;
    tick();
    n_total++;
    if (dout_b !== 8'hFD || ovf_b[1] !== 1'b1)
      $display("FAIL wrap_dec got %h ovf%b exp fd ovf1", dout_b, ovf_b[1]);
    else n_pass++;
    idle();
  endtask

  task automatic test_conflict();
    do_reset();
    Wen = 1'b1; Wsel = 2'd2; BusOut = 8'h10;
    Op = 2'b10; Osel = 2'd2; Rsel = 2'd2;
    tick();
    n_total++;
    if (dout_a !== 8'h10)
      $display("FAIL conflict_same got %h exp 10", dout_a);
    else n_pass++;
    BusOut = 8'h10; Osel = 2'd3;
    tick();
    idle();
    Rsel = 2'd2;
    #1;
    n_total++;
    if (dout_a !== 8'h10)
      $display("FAIL conflict_diff_w got %h exp 10", dout_a);
    else n_pass++;
    Rsel = 2'd3;
    #1;
    n_total++;
    if (dout_a !== 8'h02)
      $display("FAIL conflict_diff_op got %h exp 02", dout_a);
    else n_pass++;
    // Wen on a wrapping channel must win and clear ovf.
    Wen = 1'b1; Wsel = 2'd0; BusOut = 8'hFF;
    tick();
    Wen = 1'b0; Op = 2'b10; Osel = 2'd0; Rsel = 2'd0;
    tick();
    n_total++;
    if (dout_a !== 8'h00 || ovf_a[0] !== 1'b1)
      $display("FAIL conflict_wrap got %h ovf%b exp 00 ovf1", dout_a, ovf_a[0]);
    else n_pass++;
    Wen = 1'b1; BusOut = 8'hFF;
    tick();
    n_total++;
    if (dout_a !== 8'hFF || ovf_a[0] !== 1'b0)
      $display("FAIL conflict_wen_clr got %h ovf%b exp ff ovf0", dout_a, ovf_a[0]);
    else n_pass++;
    idle();
  endtask

  task automatic test_mode();
    logic ez [4];
    ez[0] = 1'b1; ez[1] = 1'b0; ez[2] = 1'b1; ez[3] = 1'b1;
    do_reset();
    Wen = 1'b1; Lwen = 1'b1; Wsel = 2'd0; BusOut = 8'h05;
    tick();
    idle();
    for (int m = 0; m < 4; m++) begin
      Cmp_mode = 2'(m);
      tick();
      n_total++;
      if (z_a[0] !== ez[m])
        $display("FAIL mode_%0d z0 got %b exp %b", m, z_a[0], ez[m]);
      else n_pass++;
    end
    Cmp_mode = 2'b00;
  endtask

  task automatic test_rst_mid();
    do_reset();
    Lwen = 1'b1; Wsel = 2'd0; BusOut = 8'h00;
    tick();
    idle();
    RST = 1'b1; Wen = 1'b1; Lwen = 1'b1; Wsel = 2'd0;
    BusOut = 8'h40; Op = 2'b10; Osel = 2'd1; Cmp_mode = 2'b11;
    tick();
    idle();
    Rsel = 2'd0;
    #1;
    n_total++;
    if (dout_a !== 8'h01 || z_a !== 4'h0)
      $display("FAIL rst_mid got %h z=%h exp 01 z=0", dout_a, z_a);
    else n_pass++;
    Cmp_mode = 2'b00;
    tick();
    n_total++;
    if (z_a !== 4'hF)
      $display("FAIL rst_mid_lim z got %h exp f", z_a);
    else n_pass++;
  endtask

  task automatic test_out_of_range();
    do_reset();
    Wen = 1'b1; Wsel = 2'd3; BusOut = 8'h55;
    Op = 2'b10; Osel = 2'd3;
    tick();
    idle();
    Rsel = 2'd3;
    #1;
    n_total++;
    if (dout_b !== 8'h00)
      $display("FAIL oor_dout got %h exp 00", dout_b);
    else n_pass++;
    for (int c = 0; c < 3; c++) begin
      Rsel = 2'(c);
      #1;
      n_total++;
      if (dout_b !== 8'h01 || ovf_b !== 3'b000)
        $display("FAIL oor_ch%0d got %h ovf=%b exp 01 ovf=0",
                 c, dout_b, ovf_b);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_loop();
    test_wrap();
    test_conflict();
    test_mode();
    test_rst_mid();
    test_out_of_range();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
